midi_uart_rx: RTL and testbench

//  MIDI serial receiver: 31250 baud, 8N1, LSB first, 16x oversampling.

---
 rtl/midi_uart_rx.sv | 152 +++++++++++++++
 tb/tb_midi_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 31250 baud 8N1, LSB first, 16x oversampled, 2-flop input synchronizer.
// Latency: data_valid rises 1 clk after the stop-bit majority vote at tick 9 of the stop bit.
// Backpressure: single valid/ack holding register; a byte finishing while unacked is dropped and flagged by overrun.
module midi_uart_rx #(
    parameter int CLK_DIV = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       framing_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rxd_m;
    logic             rxd_s;
    logic [CNT_W-1:0] presc;
    logic             tick;
    logic [3:0]       tcnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             s7;
    logic             s8;
    logic             maj;
    logic             at9;
    logic             byte_done;
    logic             frame_bad;

    // One prescaler wrap is one sixteenth of a bit period.
    assign tick = (state != IDLE) && (presc == CNT_W'(CLK_DIV - 1));
    assign at9  = tick && (tcnt == 4'd9);
    // Samples from ticks 7 and 8 are held; tick 9 uses the live synchronized input.
    assign maj  = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and the one-cycle completion / framing strobes.
    always_comb begin
        state_nxt = state;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE:  if (!rxd_s) state_nxt = START;
            START: begin
                // A start bit that is high again by mid-bit is line noise.
                if (tick && tcnt == 4'd8 && rxd_s)  state_nxt = IDLE;
                else if (tick && tcnt == 4'd15)     state_nxt = DATA;
            end
            DATA:  if (tick && tcnt == 4'd15 && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  begin
                if (at9) begin
                    if (maj) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BRK;
                    end
                end
            end
            // Wait out a held-low line so a break does not look like a new start bit.
            BRK:   if (rxd_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler and per-bit tick counter; both held at zero while idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            presc <= '0;
            tcnt  <= 4'd0;
        end else if (state == IDLE) begin
            presc <= '0;
            tcnt  <= 4'd0;
        end else if (tick) begin
            presc <= '0;
            tcnt  <= tcnt + 4'd1;
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

    // Mid-bit sampling, majority shift-in and bit indexing.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s7      <= 1'b1;
            s8      <= 1'b1;
            shreg   <= 8'h00;
            bit_idx <= 3'd0;
        end else begin
            if (tick && tcnt == 4'd7) s7 <= rxd_s;
            if (tick && tcnt == 4'd8) s8 <= rxd_s;
            if (state == START) bit_idx <= 3'd0;
            if (state == DATA) begin
                if (at9)                      shreg   <= {maj, shreg[7:1]};
                if (tick && tcnt == 4'd15)    bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Holding register handshake plus registered error pulses.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data        <= 8'h00;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun     <= 1'b0;
            if (byte_done) begin
                if (!data_valid || data_ack) begin
                    data       <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_rx.sv
module tb_midi_uart_rx;

    localparam int BIT_CLK = 64;   // CLK_DIV=4 -> 16 ticks * 4 clk
    localparam int NONE    = 99;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack = 1'b0;
    logic       framing_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // Pulse / run-length monitor
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
    int run = 0, last_run = 0;

    // Reference model: holding register seen from outside
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    int         exp_fe = 0, exp_ov = 0;

    midi_uart_rx #(.CLK_DIV(4), .CNT_W(6)) dut (
        .clk(clk), .nreset(nreset), .rxd(rxd),
        .data(data), .data_valid(data_valid), .data_ack(data_ack),
        .framing_err(framing_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (framing_err && overrun) both_cnt++;
        if (data_valid) run++;
        else begin
            if (run > 0) last_run = run;
            run = 0;
        end
    end

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) exp_fe++;
        else if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = b;
        end else exp_ov++;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
    endfunction

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    // Drive one 8N1 frame; optional 1-clk glitch in a data bit or reset mid data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int glitch_bit,
                             input int glitch_off, input int abort_bit);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop;
            else v = b[i-1];
            for (int c = 0; c < BIT_CLK; c++) begin
                if (i - 1 == abort_bit && c == 32) begin
                    nreset = 1'b0;
                    return;
                end
                rxd = (i - 1 == glitch_bit && c == glitch_off) ? ~v : v;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_state(input string name);
        total++;
        if (data !== m_data) begin
            bad++; $display("FAIL %s data: got %h want %h", name, data, m_data);
        end
        total++;
        if (data_valid !== m_valid) begin
            bad++; $display("FAIL %s data_valid: got %b want %b", name, data_valid, m_valid);
        end
        total++;
        if (fe_cnt !== exp_fe) begin
            bad++; $display("FAIL %s framing_err pulses: got %0d want %0d", name, fe_cnt, exp_fe);
        end
        total++;
        if (ov_cnt !== exp_ov) begin
            bad++; $display("FAIL %s overrun pulses: got %0d want %0d", name, ov_cnt, exp_ov);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_state("reset_held");
        nreset = 1'b1;
        idle(1000);
        check_state("reset_idle");
    endtask

    task automatic test_ack_timing();
        bit seen = 0;
        fork
            send_byte(8'h90, 1'b1, NONE, 0, NONE);
            begin
                for (int i = 0; i < 1000 && !data_valid; i++) @(negedge clk);
                seen = data_valid;
                if (seen) begin
                    repeat (5) @(negedge clk);
                    data_ack = 1'b1;
                    @(negedge clk);
                    data_ack = 1'b0;
                end
            end
        join
        idle(10);
        total++;
        if (!seen) begin
            bad++; $display("FAIL ack_timing valid_timeout: got 0 want 1");
        end
        model_frame(8'h90, 1'b1);
        m_valid = 1'b0;
        check_state("ack_0x90");
        total++;
        if (last_run !== 6) begin
            bad++; $display("FAIL ack_timing valid_len: got %0d want 6", last_run);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h3C, 1'b1, NONE, 0, NONE);
        send_byte(8'h7F, 1'b1, NONE, 0, NONE);
        model_frame(8'h3C, 1'b1);
        model_frame(8'h7F, 1'b1);
        idle(20);
        check_state("b2b_overrun");
        ack_pulse();
        idle(5);
        check_state("b2b_acked");
    endtask

    task automatic test_framing();
        send_byte(8'h55, 1'b0, NONE, 0, NONE);
        model_frame(8'h55, 1'b0);
        rxd = 1'b0;
        repeat (200) @(negedge clk);
        check_state("framing_break");
        idle(50);
        send_byte(8'h01, 1'b1, NONE, 0, NONE);
        model_frame(8'h01, 1'b1);
        idle(10);
        check_state("framing_recover");
        ack_pulse();
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        idle(200);
        check_state("idle_glitch");
        send_byte(8'hA5, 1'b1, 3, 34, NONE);
        model_frame(8'hA5, 1'b1);
        idle(10);
        check_state("bit_glitch");
    endtask

    task automatic test_reset_midframe();
        // 0xA5 still unacked, so the reset has a visible effect.
        send_byte(8'hF0, 1'b1, NONE, 0, 4);
        #1;
        model_reset();
        total++;
        if (data !== 8'h00 || data_valid !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset outputs: got %h/%b/%b/%b want 00/0/0/0",
                     data, data_valid, framing_err, overrun);
        end
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        nreset = 1'b1;
        idle(100);
        check_state("after_reset");
        send_byte(8'h0F, 1'b1, NONE, 0, NONE);
        model_frame(8'h0F, 1'b1);
        idle(10);
        check_state("post_reset_0x0F");
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_ok;
        for (int n = 0; n < 24; n++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            send_byte(b, stop_ok, NONE, 0, NONE);
            model_frame(b, stop_ok);
            check_state("random_frame");
            if ($urandom_range(0, 1) == 1) ack_pulse();
            if (stop_ok) idle($urandom_range(0, 20));
            else         idle($urandom_range(4, 20));
        end
        idle(10);
        total++;
        if (both_cnt !== 0) begin
            bad++; $display("FAIL pulse_exclusive: got %0d want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_ack_timing();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
